sys_ctrl_tx_queue: RTL and testbench
====================================

// Module: sys_ctrl_tx_queue
// PURPOSE
//  Generalised transmit-side system controller between the register file / ALU and UART_TX.
//  Every RF read response and every ALU result is queued as a tagged entry in a FIFO_DEPTH-deep FIFO.
//  Entries are serialised one byte at a time over the Busy/TX_D_VLD handshake.
//  Supports ALU results of ALU_BYTES bytes. Results arriving while a frame is in flight are never lost unless the queue is full; drops are counted.
// PARAMETERS
//  DATA_WIDTH  8  byte width of RdData, TX_P_DATA and each ALU result byte
//  ALU_BYTES   2  bytes per ALU result (1..8); ALU_OUT width = ALU_BYTES*DATA_WIDTH
//  FIFO_DEPTH  4  queue entries; power of two, >=2
//  CNT_WIDTH   8  width of the saturating drop counter
// PORTS
//  clk           in   1                     system clock, rising edge
//  reset         in   1                     async active-low reset
//  RdData        in   DATA_WIDTH            RF read data
//  RdData_Valid  in   1                     RdData valid, 1-cycle pulse
//  ALU_OUT       in   ALU_BYTES*DATA_WIDTH  ALU result
//  OUT_VALID     in   1                     ALU_OUT valid, 1-cycle pulse
//  Busy          in   1                     UART_TX busy
//  TX_P_DATA     out  DATA_WIDTH            byte to UART_TX
//  TX_D_VLD      out  1                     TX_P_DATA valid
//  q_level       out  $clog2(FIFO_DEPTH)+1  entries currently queued
//  q_full        out  1                     q_level == FIFO_DEPTH
//  drop_cnt      out  CNT_WIDTH             saturating count of rejected entries
// BEHAVIOUR
//  Reset (async, reset=0): all outputs and internal state go to 0; FSM -> IDLE; FIFO empty; any frame in progress is abandoned.
//  Entry format: {type(1b: 0=RD,1=ALU), payload ALU_BYTES*DATA_WIDTH}. RD payload is zero-extended.
//  Push: sampled on rising clk. Free slots are counted after any same-cycle pop.
//   - RdData_Valid and OUT_VALID in the same cycle: RD entry first, then ALU entry; both are written if 2 slots are free.
//   - 1 slot free: RD entry accepted, ALU entry dropped. 0 slots free: both dropped.
//   - Each dropped entry increments drop_cnt; it saturates at all-ones.
//  Frame length: RD = 1 byte; ALU = ALU_BYTES bytes, LSB byte first.
//  Transmit FSM states: IDLE, HOLD, DRAIN.
//   IDLE : on FIFO not empty and Busy==0, pop the head entry, load byte 0, set TX_D_VLD=1 and go to HOLD.
//          Otherwise stay in IDLE with TX_D_VLD=0.
//   HOLD : TX_D_VLD=1 and TX_P_DATA is stable. On Busy==1, TX_D_VLD goes to 0 and the FSM goes to DRAIN.
//   DRAIN: wait for Busy==0, then:
//          - bytes remain: load the next byte, TX_D_VLD=1, go to HOLD;
//          - frame done and FIFO not empty: pop the next entry, go to HOLD;
//          - otherwise go to IDLE.
//  Latency: a valid sampled at edge E, with the FIFO empty and UART idle, gives TX_D_VLD=1 after edge E+1.
//  Byte index counter runs 0..ALU_BYTES-1 and clears on frame end. TX_P_DATA holds its last value while TX_D_VLD=0.
//  Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle when full is legal: level is unchanged and no drop occurs.
//  Busy high while in IDLE is tolerated: no pop happens until Busy==0.
// CONFIGURATION
//  SYS_CTRL_TX_TAG_EN defined: each frame is preceded by one tag byte, 8'h52 for RD and 8'h41 for ALU, zero-extended to DATA_WIDTH.
//   The tag uses the same HOLD/DRAIN handshake. Frame length becomes 1 + payload bytes.
//  SYS_CTRL_TX_TAG_EN undefined: no tag byte; payload bytes only.
// TESTING
//  1) RdData=8'h3C with a 1-cycle RdData_Valid pulse; UART model asserts Busy 1 cycle after TX_D_VLD and holds it 10 cycles
//     -> exactly one TX_D_VLD burst with TX_P_DATA=8'h3C; q_level returns to 0.
//  2) ALU_OUT=16'hBEEF with a 1-cycle OUT_VALID pulse -> two bytes 8'hEF then 8'hBE; TX_D_VLD low for the whole DRAIN between them.
//  3) RdData=8'h11 and ALU_OUT=16'h2233 valid in the same cycle, queue empty -> bytes 8'h11, 8'h33, 8'h22 in that order; drop_cnt=0.
//  4) Busy held high; 6 RD pushes with FIFO_DEPTH=4 -> q_full=1, drop_cnt=2.
//     Release Busy -> the first 4 values are sent in order.
//  5) Assert reset while in HOLD of byte 1 of an ALU frame -> TX_D_VLD=0 and q_level=0 immediately.
//     After reset, no residual byte is sent.
//  6) Compile with SYS_CTRL_TX_TAG_EN, RdData=8'h07 -> bytes 8'h52, 8'h07.
//     ALU_OUT=16'h0102 -> bytes 8'h41, 8'h02, 8'h01.

Source files
------------

// File: rtl/sys_ctrl_tx_queue_if.sv
// Byte-stream handshake bundle between RF/ALU producers, the tx queue and UART_TX.
// master = queue side (drives TX_P_DATA/TX_D_VLD), slave = producers plus UART side.
interface sys_ctrl_tx_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_BYTES  = 2
);
    logic [DATA_WIDTH-1:0]           RdData;
    logic                            RdData_Valid;
    logic [ALU_BYTES*DATA_WIDTH-1:0] ALU_OUT;
    logic                            OUT_VALID;
    logic                            Busy;
    logic [DATA_WIDTH-1:0]           TX_P_DATA;
    logic                            TX_D_VLD;

    modport master (
        input  RdData, RdData_Valid, ALU_OUT, OUT_VALID, Busy,
        output TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RdData, RdData_Valid, ALU_OUT, OUT_VALID, Busy,
        input  TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/sys_ctrl_tx_queue.sv
// Tagged RD/ALU result queue serialised byte-by-byte onto the UART_TX Busy/TX_D_VLD handshake.
// Define SYS_CTRL_TX_TAG_EN to prefix each frame with a type tag byte (8'h52 RD, 8'h41 ALU).
module sys_ctrl_tx_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_BYTES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    sys_ctrl_tx_queue_if.master           bus,
    output logic [$clog2(FIFO_DEPTH):0]   q_level,
    output logic                          q_full,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int PAYLOAD_W = ALU_BYTES * DATA_WIDTH;
    localparam int ENTRY_W   = PAYLOAD_W + 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int IDX_W     = $clog2(ALU_BYTES + 2);
`ifdef SYS_CTRL_TX_TAG_EN
    localparam int TAG_BYTES = 1;
`else
    localparam int TAG_BYTES = 0;
`endif

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level, free_slots;
    state_t             state;
    logic [ENTRY_W-1:0] cur, head, rd_entry, alu_entry;
    logic [IDX_W-1:0]   byte_idx, last_idx;
    logic               pop, rd_acc, alu_acc;
    logic [1:0]         n_push, n_drop;
    logic [CNT_WIDTH:0] drop_sum;

    // Byte idx of a frame: optional tag at 0, then payload bytes LSB first.
    function automatic logic [DATA_WIDTH-1:0] frame_byte(input logic [ENTRY_W-1:0] e,
                                                         input logic [IDX_W-1:0]   idx);
        logic [DATA_WIDTH-1:0] b;
        b = '0;
`ifdef SYS_CTRL_TX_TAG_EN
        if (idx == '0) b = e[ENTRY_W-1] ? DATA_WIDTH'(8'h41) : DATA_WIDTH'(8'h52);
`endif
        for (int k = 0; k < ALU_BYTES; k++)
            if (idx == IDX_W'(k + TAG_BYTES)) b = e[k*DATA_WIDTH +: DATA_WIDTH];
        return b;
    endfunction

    assign head      = mem[rd_ptr];
    assign rd_entry  = {1'b0, PAYLOAD_W'(bus.RdData)};
    assign alu_entry = {1'b1, bus.ALU_OUT};
    assign last_idx  = cur[ENTRY_W-1] ? IDX_W'(ALU_BYTES - 1 + TAG_BYTES) : IDX_W'(TAG_BYTES);

    // A pop starts a frame from IDLE or chains the next frame straight out of DRAIN.
    assign pop = !bus.Busy && (level != '0) &&
                 ((state == IDLE) || ((state == DRAIN) && (byte_idx == last_idx)));

    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    always_comb begin
        free_slots = LVL_W'(FIFO_DEPTH) - level + LVL_W'(pop);
        rd_acc     = bus.RdData_Valid && (free_slots != '0);
        alu_acc    = bus.OUT_VALID && (free_slots > LVL_W'(bus.RdData_Valid));
        n_push     = 2'(rd_acc) + 2'(alu_acc);
        n_drop     = 2'(bus.RdData_Valid && !rd_acc) + 2'(bus.OUT_VALID && !alu_acc);
        drop_sum   = {1'b0, drop_cnt} + (CNT_WIDTH + 1)'(n_drop);
    end

    // NOTE: the queue is a handful of flops, so it is cleared on reset to leave no stale state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            if (rd_acc)  mem[wr_ptr] <= rd_entry;
            if (alu_acc) mem[rd_acc ? wr_ptr + PTR_W'(1) : wr_ptr] <= alu_entry;
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            level  <= level + LVL_W'(n_push) - LVL_W'(pop);
            if (n_drop != 2'd0)
                drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cur           <= '0;
            byte_idx      <= '0;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur           <= head;
                        byte_idx      <= '0;
                        bus.TX_P_DATA <= frame_byte(head, '0);
                        bus.TX_D_VLD  <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        bus.TX_D_VLD  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.Busy) begin
                        bus.TX_D_VLD <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.Busy) begin
                        if (byte_idx != last_idx) begin
                            byte_idx      <= byte_idx + IDX_W'(1);
                            bus.TX_P_DATA <= frame_byte(cur, byte_idx + IDX_W'(1));
                            bus.TX_D_VLD  <= 1'b1;
                            state         <= HOLD;
                        end else if (pop) begin
                            cur           <= head;
                            byte_idx      <= '0;
                            bus.TX_P_DATA <= frame_byte(head, '0);
                            bus.TX_D_VLD  <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            byte_idx      <= '0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q_level = level;
    assign q_full  = (level == LVL_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_sys_ctrl_tx_queue.sv
// Self-checking bench for sys_ctrl_tx_queue: UART Busy model, queue-of-entries reference model.
// Honours SYS_CTRL_TX_TAG_EN the same way as the design build.
module tb_sys_ctrl_tx_queue;

    localparam int DW = 8, AB = 2, FD = 4, CW = 8, BUSY_LEN = 10;
`ifdef SYS_CTRL_TX_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [$clog2(FD):0] q_level;
    logic q_full;
    logic [CW-1:0] drop_cnt;
    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;

    always #5 clk = ~clk;

    sys_ctrl_tx_queue_if #(.DATA_WIDTH(DW), .ALU_BYTES(AB)) bus ();
    assign bus.Busy = uart_busy | hold_busy;

    sys_ctrl_tx_queue #(.DATA_WIDTH(DW), .ALU_BYTES(AB), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .q_level(q_level), .q_full(q_full), .drop_cnt(drop_cnt)
    );

    typedef struct { bit is_alu; logic [15:0] payload; } entry_t;
    entry_t     model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int exp_drops = 0;
    int n_checks = 0, n_pass = 0;
    int vld_glitch = 0;

    // UART model: Busy rises one cycle after TX_D_VLD is seen and stays high BUSY_LEN cycles.
    int u_state = 0, u_cnt = 0;
    logic [7:0] u_last;
    always @(negedge clk) begin
        if (!reset) begin
            uart_busy = 1'b0; u_state = 0; u_cnt = 0;
        end else begin
            case (u_state)
                0: if (bus.TX_D_VLD) begin
                       rx_q.push_back(bus.TX_P_DATA); u_last = bus.TX_P_DATA; u_state = 1;
                   end
                1: begin
                       if (!bus.TX_D_VLD || bus.TX_P_DATA !== u_last) vld_glitch++;
                       uart_busy = 1'b1; u_cnt = BUSY_LEN; u_state = 2;
                   end
                default: begin
                       if (bus.TX_D_VLD) vld_glitch++;
                       u_cnt--;
                       if (u_cnt == 0) begin uart_busy = 1'b0; u_state = 0; end
                   end
            endcase
        end
    end

    // Reference model: entries are accepted RD first, then ALU, while room remains.
    task automatic model_offer(bit rd_v, logic [7:0] rd, bit alu_v, logic [15:0] alu);
        entry_t e;
        if (rd_v) begin
            if (model_q.size() < FD) begin e.is_alu = 0; e.payload = {8'h00, rd}; model_q.push_back(e); end
            else exp_drops++;
        end
        if (alu_v) begin
            if (model_q.size() < FD) begin e.is_alu = 1; e.payload = alu; model_q.push_back(e); end
            else exp_drops++;
        end
    endtask

    task automatic model_emit();
        foreach (model_q[i]) begin
            if (TAG) exp_q.push_back(model_q[i].is_alu ? 8'h41 : 8'h52);
            exp_q.push_back(model_q[i].payload[7:0]);
            if (model_q[i].is_alu) exp_q.push_back(model_q[i].payload[15:8]);
        end
        model_q.delete();
    endtask

    function automatic logic [CW-1:0] exp_drop_sat();
        return (exp_drops > 255) ? 8'hFF : CW'(exp_drops);
    endfunction

    task automatic send(bit rd_v, logic [7:0] rd, bit alu_v, logic [15:0] alu);
        @(negedge clk);
        bus.RdData = rd; bus.RdData_Valid = rd_v; bus.ALU_OUT = alu; bus.OUT_VALID = alu_v;
        @(posedge clk); #1;
        bus.RdData_Valid = 1'b0; bus.OUT_VALID = 1'b0;
        model_offer(rd_v, rd, alu_v, alu);
    endtask

    task automatic wait_rx(int n, int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk); #1;
        end
        repeat (BUSY_LEN + 8) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.RdData = '0; bus.RdData_Valid = 1'b0; bus.ALU_OUT = '0; bus.OUT_VALID = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.TX_D_VLD !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.TX_D_VLD); else n_pass++;
        n_checks++; if (bus.TX_P_DATA !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.TX_P_DATA); else n_pass++;
        n_checks++; if (q_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", q_level); else n_pass++;
        n_checks++; if (q_full !== 1'b0) $display("FAIL reset_full: got %b want 0", q_full); else n_pass++;
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_rd();
        rx_q.delete(); exp_q.delete();
        send(1, 8'h3C, 0, 16'h0000);
        model_emit();
        n_checks++; if (q_level !== 3'd1) $display("FAIL rd_level_e: got %0d want 1", q_level); else n_pass++;
        n_checks++; if (bus.TX_D_VLD !== 1'b0) $display("FAIL rd_vld_e: got %b want 0", bus.TX_D_VLD); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.TX_D_VLD !== 1'b1) $display("FAIL rd_vld_e1: got %b want 1", bus.TX_D_VLD); else n_pass++;
        n_checks++; if (bus.TX_P_DATA !== exp_q[0]) $display("FAIL rd_data_e1: got %h want %h", bus.TX_P_DATA, exp_q[0]); else n_pass++;
        wait_rx(exp_q.size(), 300);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rd_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL rd_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (q_level !== 3'd0) $display("FAIL rd_level_end: got %0d want 0", q_level); else n_pass++;
    endtask

    task automatic test_alu_frame();
        rx_q.delete(); exp_q.delete();
        send(0, 8'h00, 1, 16'hBEEF);
        model_emit();
        wait_rx(exp_q.size(), 300);
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL alu_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL alu_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (vld_glitch !== 0) $display("FAIL alu_drain_vld: got %0d glitches want 0", vld_glitch); else n_pass++;
        n_checks++; if (bus.TX_P_DATA !== 8'hBE) $display("FAIL alu_hold_data: got %h want be", bus.TX_P_DATA); else n_pass++;
    endtask

    task automatic test_same_cycle();
        rx_q.delete(); exp_q.delete();
        send(1, 8'h11, 1, 16'h2233);
        model_emit();
        wait_rx(exp_q.size(), 400);
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL dual_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL dual_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL dual_drop: got %0d want 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_fill_drop();
        rx_q.delete(); exp_q.delete();
        @(negedge clk); hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) send(1, 8'hA0 + 8'(i), 0, 16'h0000);
        n_checks++; if (q_full !== 1'b1) $display("FAIL fill_full: got %b want 1", q_full); else n_pass++;
        n_checks++; if (q_level !== 3'd4) $display("FAIL fill_level: got %0d want 4", q_level); else n_pass++;
        n_checks++; if (drop_cnt !== exp_drop_sat()) $display("FAIL fill_drop: got %0d want %0d", drop_cnt, exp_drop_sat()); else n_pass++;
        @(negedge clk); hold_busy = 1'b0;
        model_emit();
        wait_rx(exp_q.size(), 600);
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL fill_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL fill_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_push_pop_full();
        rx_q.delete(); exp_q.delete();
        @(negedge clk); hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 8'hC0 + 8'(i), 0, 16'h0000);
        n_checks++; if (q_full !== 1'b1) $display("FAIL pp_full: got %b want 1", q_full); else n_pass++;
        model_emit();
        @(negedge clk);
        hold_busy = 1'b0; bus.RdData = 8'h5A; bus.RdData_Valid = 1'b1;
        @(posedge clk); #1;
        bus.RdData_Valid = 1'b0;
        model_offer(1, 8'h5A, 0, 16'h0000);
        n_checks++; if (q_level !== 3'd4) $display("FAIL pp_level: got %0d want 4", q_level); else n_pass++;
        n_checks++; if (drop_cnt !== exp_drop_sat()) $display("FAIL pp_drop: got %0d want %0d", drop_cnt, exp_drop_sat()); else n_pass++;
        n_checks++; if (bus.TX_D_VLD !== 1'b1) $display("FAIL pp_vld: got %b want 1", bus.TX_D_VLD); else n_pass++;
        model_emit();
        wait_rx(exp_q.size(), 600);
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL pp_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL pp_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_q.delete(); exp_q.delete();
        send(0, 8'h00, 1, 16'hBEEF);
        send(1, 8'h77, 0, 16'h0000);
        model_emit();
        for (int i = 0; i < 300 && rx_q.size() < 2; i++) begin @(negedge clk); #1; end
        reset = 1'b0;
        #1;
        exp_drops = 0;
        n_checks++; if (bus.TX_D_VLD !== 1'b0) $display("FAIL mid_vld: got %b want 0", bus.TX_D_VLD); else n_pass++;
        n_checks++; if (q_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", q_level); else n_pass++;
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL mid_drop: got %0d want 0", drop_cnt); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        n_checks++; if (rx_q.size() != 2) $display("FAIL mid_residual: got %0d bytes want 2", rx_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL mid_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int nev;
            rx_q.delete(); exp_q.delete();
            @(negedge clk); hold_busy = 1'b1;
            nev = int'($urandom_range(1, 7));
            for (int e = 0; e < nev; e++) begin
                bit rv, av;
                rv = 1'($urandom); av = 1'($urandom);
                if (!rv && !av) rv = 1'b1;
                send(rv, 8'($urandom), av, 16'($urandom));
            end
            n_checks++; if (q_level !== 3'(model_q.size())) $display("FAIL rnd%0d_level: got %0d want %0d", r, q_level, model_q.size()); else n_pass++;
            n_checks++; if (q_full !== (model_q.size() == FD)) $display("FAIL rnd%0d_full: got %b want %b", r, q_full, model_q.size() == FD); else n_pass++;
            n_checks++; if (drop_cnt !== exp_drop_sat()) $display("FAIL rnd%0d_drop: got %0d want %0d", r, drop_cnt, exp_drop_sat()); else n_pass++;
            @(negedge clk); hold_busy = 1'b0;
            model_emit();
            wait_rx(exp_q.size(), 800);
            n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rnd%0d_len: got %0d want %0d", r, rx_q.size(), exp_q.size()); else n_pass++;
            foreach (exp_q[i]) begin
                n_checks++;
                if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL rnd%0d_byte%0d: got %h want %h", r, i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_drop_saturate();
        @(negedge clk); hold_busy = 1'b1;
        for (int i = 0; i < FD; i++) send(1, 8'(i), 0, 16'h0000);
        for (int i = 0; i < 10; i++) send(1, 8'hEE, 1, 16'h1234);
        n_checks++; if (drop_cnt !== exp_drop_sat()) $display("FAIL sat_mid: got %0d want %0d", drop_cnt, exp_drop_sat()); else n_pass++;
        for (int i = 0; i < 130; i++) send(1, 8'hEE, 1, 16'h1234);
        n_checks++; if (drop_cnt !== 8'hFF) $display("FAIL sat_end: got %0d want 255", drop_cnt); else n_pass++;
        n_checks++; if (q_level !== 3'd4) $display("FAIL sat_level: got %0d want 4", q_level); else n_pass++;
        n_checks++; if (vld_glitch !== 0) $display("FAIL handshake_vld: got %0d glitches want 0", vld_glitch); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_alu_frame();
        test_same_cycle();
        test_fill_drop();
        test_push_pop_full();
        test_reset_mid_frame();
        test_random();
        test_drop_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
